// File: rtl/debug_uart_tx.sv
// Byte-wide debug UART transmitter: a small circular FIFO feeding an 8N1 serializer.
// Frames are sent back-to-back while bytes are queued; tx idles high.
module debug_uart_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       tx,
    output logic       busy,
    output logic       full,
    output logic [1:0] dbg_state
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Transmit FIFO
    // ------------------------------------------------------------------
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;
    logic             fifo_empty;

    // wr_en acts as valid with an implicit ready of !full: a byte is accepted
    // on any edge where wr_en=1 and full=0, and silently dropped otherwise.
    assign full       = (count == DEPTH_C);
    assign fifo_empty = (count == '0);
    assign push       = wr_en && !full;

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Serializer FSM
    // ------------------------------------------------------------------
    state_t            state_q;
    state_t            state_d;
    logic [BAUD_W-1:0] baud_q;
    logic [BAUD_W-1:0] baud_d;
    logic [2:0]        bit_q;
    logic [2:0]        bit_d;
    logic [7:0]        shreg_q;
    logic [7:0]        shreg_d;
    logic              tx_q;
    logic              tx_d;
    logic              bit_done;

    assign bit_done = (baud_q == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
        end
    end

    // tx_d is the value the line takes for the whole of the next bit, so each
    // transition loads the shift register and the first line level together.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        tx_d    = tx_q;
        pop     = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shreg_d = mem[rd_ptr];
                    tx_d    = 1'b0;
                    baud_d  = '0;
                    state_d = START;
                end
            end

            START: begin
                if (bit_done) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = shreg_q[0];
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end

            DATA: begin
                if (bit_done) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shreg_d = {1'b0, shreg_q[7:1]};
                        tx_d    = shreg_q[1];
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end

            STOP: begin
                if (bit_done) begin
                    baud_d = '0;
                    // Chain straight into the next start bit when more data waits.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shreg_d = mem[rd_ptr];
                        tx_d    = 1'b0;
                        state_d = START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end

            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    assign tx        = tx_q;
    assign busy      = (state_q != IDLE) || !fifo_empty;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_debug_uart_tx.sv
// Directed bench for debug_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4): drives bytes,
// records tx at falling edges and compares whole frames against queued bytes.
module tb_debug_uart_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       tx;
    logic       busy;
    logic       full;
    logic [1:0] dbg_state;

    int total = 0;
    int bad   = 0;

    logic       tx_s[$];
    logic [7:0] exp_q[$];

    debug_uart_tx #(
        .CLKS_PER_BIT(4),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .tx       (tx),
        .busy     (busy),
        .full     (full),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic apply_reset();
        rst   = 1'b1;
        wr_en = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- drivers / samplers ----------------
    task automatic write_byte(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic sample(input int n);
        repeat (n) begin
            @(negedge clk);
            tx_s.push_back(tx);
        end
    endtask

    task automatic count_low(input int n, output int lows);
        lows = 0;
        repeat (n) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
    endtask

    function automatic int zeros_in(input int base, input int n);
        int z = 0;
        for (int i = base; i < base + n; i++) begin
            if (tx_s[i] == 1'b0) z++;
        end
        return z;
    endfunction

    // Compares 10 bits x 4 samples starting at tx_s[base] with the next expected byte.
    task automatic check_frame(input string tag, input int base);
        logic [7:0] d;
        logic [3:0] got;
        logic       b;
        if (exp_q.size() == 0 || tx_s.size() < base + 40) begin
            check({tag, "_avail"}, 32'd0, 32'd1);
            return;
        end
        d = exp_q.pop_front();
        for (int k = 0; k < 10; k++) begin
            if (k == 0)      b = 1'b0;
            else if (k == 9) b = 1'b1;
            else             b = d[k-1];
            got = {tx_s[base+4*k+3], tx_s[base+4*k+2], tx_s[base+4*k+1], tx_s[base+4*k]};
            check($sformatf("%s_bit%0d", tag, k), 32'(got), {28'd0, {4{b}}});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        int lows;
        int low_at;

        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_data = 8'h00;

        // Reset state, and a write during reset must be discarded.
        repeat (2) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        wr_en   = 1'b1;
        wr_data = 8'h99;
        @(negedge clk);
        wr_en = 1'b0;
        rst   = 1'b0;
        count_low(50, lows);
        check("idle_low_cycles", lows, 32'd0);
        check("idle_busy", 32'(busy), 32'd0);

        // Single byte 0x55, latency one edge, busy falls 40 cycles after start.
        tx_s.delete();
        exp_q.push_back(8'h55);
        write_byte(8'h55);
        sample(40);
        check_frame("b55", 0);
        check("b55_busy_last", 32'(busy), 32'd1);
        @(negedge clk);
        check("b55_busy_fall", 32'(busy), 32'd0);
        check("b55_tx_idle", 32'(tx), 32'd1);

        // Fill, full flag and drop of the sixth byte; frames back-to-back.
        apply_reset();
        tx_s.delete();
        for (int j = 1; j <= 5; j++) exp_q.push_back(8'(j));
        for (int j = 0; j < 6; j++) begin
            wr_en   = 1'b1;
            wr_data = 8'(j + 1);
            @(negedge clk);
            if (j >= 1) tx_s.push_back(tx);
            if (j == 3) check("fill_not_full", 32'(full), 32'd0);
            if (j == 4) check("fill_full", 32'(full), 32'd1);
        end
        wr_en = 1'b0;
        check("drop_still_full", 32'(full), 32'd1);
        sample(195);
        for (int f = 0; f < 5; f++) check_frame($sformatf("seq%0d", f), 40 * f);
        check("seq_busy_last", 32'(busy), 32'd1);
        @(negedge clk);
        check("seq_busy_fall", 32'(busy), 32'd0);
        check("seq_full_clear", 32'(full), 32'd0);
        count_low(40, lows);
        check("seq_no_sixth", lows, 32'd0);

        // Boundary data 0x00 then 0xFF.
        apply_reset();
        tx_s.delete();
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        wr_en   = 1'b1;
        wr_data = 8'h00;
        @(negedge clk);
        wr_data = 8'hFF;
        @(negedge clk);
        tx_s.push_back(tx);
        wr_en = 1'b0;
        sample(79);
        check_frame("b00", 0);
        check_frame("bff", 40);
        check("b00_low_run", zeros_in(0, 40), 32'd36);
        check("bff_low_run", zeros_in(40, 40), 32'd4);

        // Reset during data bit 3 of 0xA5 with 0x3C queued.
        apply_reset();
        write_byte(8'hA5);
        write_byte(8'h3C);
        repeat (16) @(negedge clk);
        check("abort_pre_bit3", 32'(tx), 32'd0);
        check("abort_pre_state", 32'(dbg_state), 32'd2);
        rst = 1'b1;
        @(negedge clk);
        check("abort_tx", 32'(tx), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_full", 32'(full), 32'd0);
        check("abort_state", 32'(dbg_state), 32'd0);
        rst = 1'b0;
        count_low(80, lows);
        check("abort_no_3c", lows, 32'd0);
        check("abort_busy_after", 32'(busy), 32'd0);

        // Write lands on the edge STOP ends with an empty FIFO.
        apply_reset();
        tx_s.delete();
        exp_q.push_back(8'h5A);
        write_byte(8'h5A);
        sample(40);
        check_frame("sim_first", 0);
        wr_en   = 1'b1;
        wr_data = 8'hC3;
        @(negedge clk);
        wr_en = 1'b0;
        tx_s.delete();
        tx_s.push_back(tx);
        sample(41);
        if (tx_s[0] == 1'b0)      low_at = 0;
        else if (tx_s[1] == 1'b0) low_at = 1;
        else                      low_at = -1;
        check("sim_start_gap", 32'(low_at >= 0), 32'd1);
        if (low_at >= 0) begin
            exp_q.push_back(8'hC3);
            check_frame("sim_c3", low_at);
        end
        repeat (2) @(negedge clk);
        check("sim_busy_end", 32'(busy), 32'd0);

        check("exp_q_drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/debug_uart_tx.md
DEBUG_UART_TX -- requirements
Module: debug_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 4, meaning clock cycles per serial bit (legal range 2..65535).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of byte entries in the transmit FIFO (power of two, at least 2).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port wr_en, input, 1 bit: CPU store strobe; one byte is offered per cycle in which it is high.
REQ-006 SHALL have port wr_data, input, 8 bits: the byte to transmit, sampled when wr_en is high.
REQ-007 SHALL have port tx, output, 1 bit: registered serial line (8N1, idle high); the machine routes it to its debug pin.
REQ-008 SHALL have port busy, output, 1 bit: high while the FIFO is non-empty or a frame is in progress.
REQ-009 SHALL have port full, output, 1 bit: high when the FIFO holds FIFO_DEPTH entries.

Function
REQ-010 SHALL hold the FIFO as circular storage with read and write pointers of width log2(FIFO_DEPTH) that wrap modulo FIFO_DEPTH, and a count of width log2(FIFO_DEPTH)+1 ranging 0..FIFO_DEPTH.
REQ-011 SHALL push wr_data at the rising edge when wr_en=1 and full=0.
REQ-012 SHALL drop a write when wr_en=1 and full=1, leaving FIFO contents, pointers and count unchanged, even if a pop occurs in the same cycle.
REQ-013 SHALL update the count by +1 on push only, -1 on pop only, and leave it unchanged on a simultaneous push and pop.
REQ-014 SHALL use a four-state FSM: IDLE, START, DATA, STOP.
REQ-015 In IDLE with the FIFO non-empty, the FSM SHALL pop the head byte into an 8-bit shift register, drive tx=0, and enter START on the same edge.
REQ-016 In IDLE with the FIFO empty, the FSM SHALL hold tx=1.
REQ-017 SHALL keep tx at each bit value for exactly CLKS_PER_BIT cycles, timed by a baud counter that reloads at every bit boundary.
REQ-018 At the end of START, the FSM SHALL enter DATA and drive bit 0 of the shift register.
REQ-019 In DATA, the FSM SHALL send bits LSB first, tracked by a 3-bit bit counter; after bit 7 completes it SHALL enter STOP with tx=1.
REQ-020 At the end of STOP, the FSM SHALL pop the next byte and enter START on that same edge if the FIFO is non-empty (no idle gap between frames); otherwise it SHALL enter IDLE.
REQ-021 Each frame SHALL last exactly 10*CLKS_PER_BIT cycles.
REQ-022 Latency: a byte pushed into an empty FIFO with the FSM in IDLE at edge N SHALL be popped at edge N+1, with tx=0 from edge N+1.
REQ-023 busy SHALL be combinational from the registered state: (state != IDLE) or (count != 0).
REQ-024 full SHALL be combinational: (count == FIFO_DEPTH).
REQ-025 A write landing in the same cycle as a pop from an empty-after-pop FIFO SHALL be retained and transmitted next.

Reset
REQ-026 When rst=1 at a rising edge, the block SHALL set state=IDLE, tx=1, the FIFO pointers and count to 0, and the baud and bit counters to 0, giving busy=0 and full=0 after that edge.
REQ-027 Reset SHALL take priority over wr_en in the same cycle; that write SHALL be discarded.
REQ-028 Reset mid-frame SHALL abort the frame and return tx to 1 at that edge; queued bytes SHALL be lost.

Verification
REQ-029 SHALL cover reset: hold rst high for 2 cycles -> tx=1, busy=0, full=0, and tx stays 1 for 50 cycles with no writes.
REQ-030 SHALL cover a single byte: with CLKS_PER_BIT=4, write 0x55 -> tx shows 0,1,0,1,0,1,0,1,0,1 for 4 cycles each, starting one edge after the write, and busy falls exactly 40 cycles after tx first goes low.
REQ-031 SHALL cover full and drop: write 0x01..0x06 on 6 consecutive cycles -> 0x01 popped immediately, full=1 after the 5th write, 0x06 dropped, and 0x01..0x05 sent back-to-back in 200 cycles with no idle bits between frames.
REQ-032 SHALL cover boundary data: write 0x00, then 0xFF -> first frame shows tx low for 36 cycles then high for 4; second frame shows low for 4 then high for 36.
REQ-033 SHALL cover reset mid-frame: queue 0xA5 and 0x3C, assert rst during DATA bit 3 -> tx=1 at that edge, busy=0, and 0x3C is never transmitted.
REQ-034 SHALL cover a simultaneous event: write a new byte on the exact cycle STOP ends with the FIFO empty -> that byte is transmitted immediately, or after a single IDLE cycle, and never lost.
